// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg
//   Shared definitions for the data-memory arbiter:
//   - sequencer state encoding,
//   - access size codes,
//   - the highest legal word address for a given byte-address width.
package dm_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef logic [1:0] size_t;

  localparam size_t SZ_BYTE = 2'b00;
  localparam size_t SZ_HALF = 2'b01;
  localparam size_t SZ_WORD = 2'b10;  // 2'b11 is also treated as a word

  // A whole 32-bit word must fit, so the last legal byte address is 2^aw - 4.
  function automatic logic [31:0] addr_max(input int unsigned aw);
    return (32'd1 << aw) - 32'd4;
  endfunction

  // Byte and halfword stores need a read-modify-write sequence.
  function automatic logic is_sub_word(input size_t sz);
    return (sz == SZ_BYTE) || (sz == SZ_HALF);
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if
//   Bundle of both requester ports plus the data-memory port.
//   Modports:
//     slave  - arbiter side: takes requests and dm_dout, drives acks,
//              errors, read data and the memory controls.
//     master - environment side (requesters and memory): the reverse.
//   Per requester: req, wr, size, addr, wdata in; ack, err, rdata out.
//   Memory: dm_cs, dm_rd, dm_wr, dm_addr, dm_din out; dm_dout in.
interface dm_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);

  logic              m0_req,   m1_req;
  logic              m0_wr,    m1_wr;
  logic [1:0]        m0_size,  m1_size;
  logic [ADDR_W-1:0] m0_addr,  m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_ack,   m1_ack;
  logic              m0_err,   m1_err;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;

  logic              dm_cs;
  logic              dm_rd;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_din;
  logic [DATA_W-1:0] dm_dout;

  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_size, m1_size,
           m0_addr, m1_addr, m0_wdata, m1_wdata, dm_dout,
    output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
           dm_cs, dm_rd, dm_wr, dm_addr, dm_din
  );

  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_size, m1_size,
           m0_addr, m1_addr, m0_wdata, m1_wdata, dm_dout,
    input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
           dm_cs, dm_rd, dm_wr, dm_addr, dm_din
  );

endinterface

// File: rtl/dm_store_merge.sv
// dm_store_merge
//   Combinational insertion of right-justified store data into a word read
//   back from memory. The memory is big-endian, so the addressed byte or
//   halfword occupies the most significant bits of the word.
//   Ports:
//     size   in  access size code
//     wdata  in  store data, right-justified
//     merge  in  word previously read from memory
//     merged out word to write back (wdata itself for word stores)
module dm_store_merge
  import dm_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  size_t             size,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] merge,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    merged = wdata;
    case (size)
      SZ_BYTE: merged = {wdata[7:0],  merge[DATA_W-9:0]};
      SZ_HALF: merged = {wdata[15:0], merge[DATA_W-17:0]};
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Round-robin arbiter and access sequencer for a two-master, word-wide data
//   memory. Port 0 is the pipeline MEM stage, port 1 the I/O/DMA master.
//   Each grant runs a fixed sequence:
//     - word access and sub-word load: ACCESS -> DONE;
//     - sub-word store: RMW_RD -> RMW_WR -> DONE (read-modify-write);
//     - out-of-range address: straight to DONE with err, no memory access.
//   Ports:
//     clk      in  rising-edge clock
//     reset_n  in  asynchronous active-low reset
//     bus      dm_arbiter_if.slave: requester ports and memory port
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         reset_n,
  dm_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(addr_max(ADDR_W));

  state_t            state_q, state_d;
  logic              last_q;      // master granted most recently
  logic              owner_q;     // master owning the current transaction
  logic              wr_q;
  size_t             size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [DATA_W-1:0] merged;

  logic              grant;
  logic              grant_m1;
  logic              sel_wr;
  size_t             sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;

  // m1 wins when it is alone, or on a tie when m0 was served last.
  assign grant_m1  = bus.m1_req && (!bus.m0_req || !last_q);
  assign sel_wr    = grant_m1 ? bus.m1_wr    : bus.m0_wr;
  assign sel_size  = grant_m1 ? bus.m1_size  : bus.m0_size;
  assign sel_addr  = grant_m1 ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = grant_m1 ? bus.m1_wdata : bus.m0_wdata;
  assign sel_err   = sel_addr > ADDR_LIMIT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory controls depend only on the sequencer state (and the latched
  // direction in ACCESS), so an asynchronous reset drops them at once.
  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    bus.dm_cs  = 1'b0;
    bus.dm_rd  = 1'b0;
    bus.dm_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          grant = 1'b1;
          if (sel_err) begin
            state_d = DONE;
          end else if (sel_wr && is_sub_word(sel_size)) begin
            state_d = RMW_RD;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        bus.dm_cs = 1'b1;
        bus.dm_rd = !wr_q;
        bus.dm_wr = wr_q;
        state_d   = DONE;
      end
      RMW_RD: begin
        bus.dm_cs = 1'b1;
        bus.dm_rd = 1'b1;
        state_d   = RMW_WR;
      end
      RMW_WR: begin
        bus.dm_cs = 1'b1;
        bus.dm_wr = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        // Requests are ignored here, so a req still high is not re-served.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      merge_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (grant) begin
        owner_q <= grant_m1;
        last_q  <= grant_m1;
        wr_q    <= sel_wr;
        size_q  <= sel_size;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        err_q   <= sel_err;
        // An error transaction returns zero read data.
        if (sel_err) begin
          if (grant_m1) rdata1_q <= '0;
          else          rdata0_q <= '0;
        end
      end
      if (state_q == ACCESS && !wr_q) begin
        if (owner_q) rdata1_q <= bus.dm_dout;
        else         rdata0_q <= bus.dm_dout;
      end
      if (state_q == RMW_RD) begin
        merge_q <= bus.dm_dout;
      end
    end
  end

  dm_store_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .size   (size_q),
    .wdata  (wdata_q),
    .merge  (merge_q),
    .merged (merged)
  );

  assign bus.dm_addr  = addr_q;
  assign bus.dm_din   = merged;

  assign bus.m0_ack   = (state_q == DONE) && !owner_q;
  assign bus.m1_ack   = (state_q == DONE) &&  owner_q;
  assign bus.m0_err   = bus.m0_ack && err_q;
  assign bus.m1_err   = bus.m1_ack && err_q;
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
//   Directed bench for dm_arbiter with a big-endian byte-array memory model.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic       clk;
  logic       reset_n;
  logic       mem_clr;
  logic [7:0] mem [0:4095];
  int         n_cmp = 0;
  int         n_bad = 0;

  dm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational big-endian read, write on the rising edge.
  assign bus.dm_dout = {mem[bus.dm_addr], mem[bus.dm_addr + 12'd1],
                        mem[bus.dm_addr + 12'd2], mem[bus.dm_addr + 12'd3]};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (bus.dm_cs && bus.dm_wr) begin
      mem[bus.dm_addr]         <= bus.dm_din[31:24];
      mem[bus.dm_addr + 12'd1] <= bus.dm_din[23:16];
      mem[bus.dm_addr + 12'd2] <= bus.dm_din[15:8];
      mem[bus.dm_addr + 12'd3] <= bus.dm_din[7:0];
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic wr, input logic [1:0] sz,
                       input logic [11:0] a, input logic [31:0] d);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_wr = wr; bus.m0_size = sz; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = req; bus.m1_wr = wr; bus.m1_size = sz; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? bus.m0_ack : bus.m1_ack;
  endfunction

  function automatic logic err_of(input int m);
    return (m == 0) ? bus.m0_err : bus.m1_err;
  endfunction

  function automatic logic [31:0] rdata_of(input int m);
    return (m == 0) ? bus.m0_rdata : bus.m1_rdata;
  endfunction

  task automatic check_reset(input string tag);
    chk1({tag, " m0_ack"},   bus.m0_ack, 1'b0);
    chk1({tag, " m1_ack"},   bus.m1_ack, 1'b0);
    chk1({tag, " m0_err"},   bus.m0_err, 1'b0);
    chk1({tag, " m1_err"},   bus.m1_err, 1'b0);
    chk32({tag, " m0_rdata"}, bus.m0_rdata, 32'h0);
    chk32({tag, " m1_rdata"}, bus.m1_rdata, 32'h0);
    chk1({tag, " dm_cs"},    bus.dm_cs, 1'b0);
    chk1({tag, " dm_rd"},    bus.dm_rd, 1'b0);
    chk1({tag, " dm_wr"},    bus.dm_wr, 1'b0);
    chk32({tag, " dm_addr"}, 32'(bus.dm_addr), 32'h0);
    chk32({tag, " dm_din"},  bus.dm_din, 32'h0);
  endtask

  // One transaction from IDLE: request at cycle 0, ack expected exactly at
  // ack_cyc, request dropped in the ack cycle, ack low in the cycle after.
  task automatic xact(input string tag, input int m, input logic wr, input logic [1:0] sz,
                      input logic [11:0] a, input logic [31:0] d, input int ack_cyc,
                      input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err);
    drive(m, 1'b1, wr, sz, a, d);
    for (int c = 1; c <= ack_cyc; c++) begin
      @(negedge clk);
      chk1({tag, " ack"}, ack_of(m), (c == ack_cyc));
      if (exp_err) chk1({tag, " no dm_cs"}, bus.dm_cs, 1'b0);
    end
    chk1({tag, " err"}, err_of(m), exp_err);
    if (chk_rd) chk32({tag, " rdata"}, rdata_of(m), exp_rd);
    drive(m, 1'b0, wr, sz, a, d);
    @(negedge clk);
    chk1({tag, " ack drop"}, ack_of(m), 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    mem_clr = 1'b1;
    drive(0, 1'b0, 1'b0, SZ_WORD, 12'h000, 32'h0);
    drive(1, 1'b0, 1'b0, SZ_WORD, 12'h000, 32'h0);
    repeat (3) @(negedge clk);
    check_reset("reset");
    mem_clr = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // Word store: ACCESS in cycle 1, ack in cycle 2.
    drive(0, 1'b1, 1'b1, SZ_WORD, 12'h010, 32'hDEADBEEF);
    @(negedge clk);
    chk1("wst cs", bus.dm_cs, 1'b1);
    chk1("wst wr", bus.dm_wr, 1'b1);
    chk1("wst rd", bus.dm_rd, 1'b0);
    chk32("wst addr", 32'(bus.dm_addr), 32'h010);
    chk32("wst din", bus.dm_din, 32'hDEADBEEF);
    chk1("wst ack c1", bus.m0_ack, 1'b0);
    @(negedge clk);
    chk1("wst ack c2", bus.m0_ack, 1'b1);
    chk1("wst cs c2", bus.dm_cs, 1'b0);
    drive(0, 1'b0, 1'b1, SZ_WORD, 12'h010, 32'hDEADBEEF);
    @(negedge clk);
    chk1("wst ack c3", bus.m0_ack, 1'b0);

    xact("wld 010", 0, 1'b0, SZ_WORD, 12'h010, 32'h0, 2, 1'b1, 32'hDEADBEEF, 1'b0);
    xact("wst 020", 0, 1'b1, SZ_WORD, 12'h020, 32'h11223344, 2, 1'b0, 32'h0, 1'b0);

    // m1 byte store: RMW_RD in cycle 1, RMW_WR in cycle 2, ack in cycle 3.
    // wdata changes after grant and must not affect the write.
    drive(1, 1'b1, 1'b1, SZ_BYTE, 12'h020, 32'h000000AA);
    @(negedge clk);
    chk1("bst c1 cs", bus.dm_cs, 1'b1);
    chk1("bst c1 rd", bus.dm_rd, 1'b1);
    chk1("bst c1 wr", bus.dm_wr, 1'b0);
    chk32("bst c1 addr", 32'(bus.dm_addr), 32'h020);
    bus.m1_wdata = 32'h00000055;
    @(negedge clk);
    chk1("bst c2 rd", bus.dm_rd, 1'b0);
    chk1("bst c2 wr", bus.dm_wr, 1'b1);
    chk32("bst c2 din", bus.dm_din, 32'hAA223344);
    chk1("bst c2 ack", bus.m1_ack, 1'b0);
    @(negedge clk);
    chk1("bst c3 ack", bus.m1_ack, 1'b1);
    chk1("bst c3 m0 ack", bus.m0_ack, 1'b0);
    chk1("bst c3 err", bus.m1_err, 1'b0);
    drive(1, 1'b0, 1'b1, SZ_BYTE, 12'h020, 32'h00000055);
    @(negedge clk);
    chk1("bst c4 ack", bus.m1_ack, 1'b0);

    xact("hst 020", 0, 1'b1, SZ_HALF, 12'h020, 32'h0000BEEF, 3, 1'b0, 32'h0, 1'b0);
    xact("wld 020", 0, 1'b0, SZ_WORD, 12'h020, 32'h0, 2, 1'b1, 32'hBEEF3344, 1'b0);
    xact("bld 020", 1, 1'b0, SZ_BYTE, 12'h020, 32'h0, 2, 1'b1, 32'hBEEF3344, 1'b0);

    // Out-of-range word load: ack with err in cycle 1, rdata cleared.
    xact("err FFE", 1, 1'b0, SZ_WORD, 12'hFFE, 32'h0, 1, 1'b1, 32'h0, 1'b1);
    // Highest legal word address.
    xact("wst FFC", 1, 1'b1, SZ_WORD, 12'hFFC, 32'hCAFEF00D, 2, 1'b0, 32'h0, 1'b0);
    xact("wld FFC", 1, 1'b0, SZ_WORD, 12'hFFC, 32'h0, 2, 1'b1, 32'hCAFEF00D, 1'b0);

    // Reset asserted during RMW_WR.
    drive(0, 1'b1, 1'b1, SZ_BYTE, 12'h020, 32'h00000077);
    @(negedge clk);
    chk1("rst rmw c1 rd", bus.dm_rd, 1'b1);
    @(negedge clk);
    chk1("rst rmw c2 wr", bus.dm_wr, 1'b1);
    chk32("rst rmw c2 din", bus.dm_din, 32'h77EF3344);
    #1 reset_n = 1'b0;
    #1;
    chk1("rst async wr", bus.dm_wr, 1'b0);
    chk1("rst async cs", bus.dm_cs, 1'b0);
    drive(0, 1'b0, 1'b0, SZ_WORD, 12'h000, 32'h0);
    @(negedge clk);
    check_reset("rst rmw");
    reset_n = 1'b1;
    @(negedge clk);
    xact("reread 020", 0, 1'b0, SZ_WORD, 12'h020, 32'h0, 2, 1'b1, 32'hBEEF3344, 1'b0);

    // Both masters requesting continuously from reset: m0, m1, m0, m1.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, SZ_WORD, 12'h100, 32'h01010101);
    drive(1, 1'b1, 1'b1, SZ_WORD, 12'h104, 32'h02020202);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk1($sformatf("rr m0 ack c%0d", c), bus.m0_ack, (c == 2 || c == 8));
      chk1($sformatf("rr m1 ack c%0d", c), bus.m1_ack, (c == 5 || c == 11));
    end
    drive(0, 1'b0, 1'b0, SZ_WORD, 12'h000, 32'h0);
    drive(1, 1'b0, 1'b0, SZ_WORD, 12'h000, 32'h0);
    @(negedge clk);
    chk1("rr idle m0", bus.m0_ack, 1'b0);
    chk1("rr idle m1", bus.m1_ack, 1'b0);
    xact("rr ld 100", 0, 1'b0, SZ_WORD, 12'h100, 32'h0, 2, 1'b1, 32'h01010101, 1'b0);
    xact("rr ld 104", 1, 1'b0, SZ_WORD, 12'h104, 32'h0, 2, 1'b1, 32'h02020202, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-master arbiter and access sequencer for the byte-addressed 4096×8 data memory. Port 0 is the pipeline MEM stage, port 1 the I/O/DMA master. Each granted request runs as a short fixed sequence that drives the memory's `dm_cs`/`dm_rd`/`dm_wr` controls. Byte and halfword stores become read-modify-write sequences, because the memory only writes whole 32-bit words.

## Interface

Parameters:

- `ADDR_W`, 12, memory byte-address width
- `DATA_W`, 32, word width

Ports:

- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `m0_req`, `m1_req`  in  1  request; held with attributes until ack
- `m0_wr`, `m1_wr`  in  1  1 = store, 0 = load
- `m0_size`, `m1_size`  in  2  00 byte, 01 half, 10/11 word
- `m0_addr`, `m1_addr`  in  ADDR_W  byte address
- `m0_wdata`, `m1_wdata`  in  DATA_W  store data, right-justified for byte/half
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse
- `m0_err`, `m1_err`  out  1  pulses with ack on an address-range error
- `m0_rdata`, `m1_rdata`  out  DATA_W  load data, valid while ack is high
- `dm_cs`, `dm_rd`, `dm_wr`  out  1  memory controls
- `dm_addr`  out  ADDR_W  memory address
- `dm_din`  out  DATA_W  memory write data
- `dm_dout`  in  DATA_W  memory read data (combinational)

## Operation

- States: IDLE, ACCESS, RMW_RD, RMW_WR, DONE.
- Arbitration happens only in IDLE, using round-robin with a `last` register.
  - A lone requester wins.
  - When both request, the master that was not `last` wins.
  - `last` resets to 1, so m0 wins the first tie.
- On grant, latch `owner`, `wr`, `size`, `addr` and `wdata`, and update `last`.
- IDLE transitions:
  - word access → ACCESS;
  - byte/half store → RMW_RD;
  - byte/half load → ACCESS, returning the full word;
  - `addr > 2^ADDR_W-4` → DONE with err.
- ACCESS:
  - Assert `dm_cs`, plus `dm_rd` for a load or `dm_wr` for a store.
  - A store commits at the edge that leaves ACCESS.
  - A load captures `dm_dout` into the owner's `rdata` register.
  - Next state: DONE.
- RMW_RD: assert `dm_cs` and `dm_rd`, capture `dm_dout` into the merge register, then go to RMW_WR.
- RMW_WR:
  - Assert `dm_cs` and `dm_wr`.
  - `dm_din` is the merge value:
    - byte: `{wdata[7:0], merge[23:0]}`;
    - half: `{wdata[15:0], merge[15:0]}`.
  - The memory is big-endian, so the byte at `addr` is bits [31:24].
  - Next state: DONE.
- DONE:
  - The owner's ack is high for exactly this cycle.
  - Requests are ignored, so a `req` still high during DONE is not re-served.
  - Next state: IDLE.
- `dm_addr` and `dm_din` are driven from latched values; `dm_din` equals `wdata` for a word store.
- The memory control outputs are decoded from state only.
- An error transaction performs no memory access, returns `rdata` = 0, and pulses err together with ack.
- Alignment is not enforced; any in-range address is legal.

## Timing

- Reset, asynchronous: state = IDLE, `last` = 1.
- Reset values of outputs and registers:
  - all acks and errs = 0;
  - both `rdata` = 0;
  - `dm_cs`, `dm_rd`, `dm_wr` = 0;
  - `dm_addr` = 0, `dm_din` = 0;
  - merge = 0.
- Cycle latency from `req` seen in IDLE (cycle 0):

| Transaction | Memory cycle(s) | Ack cycle | Earliest next grant |
|---|---|---|---|
| Word load/store | ACCESS in cycle 1 | cycle 2 | cycle 3 |
| Byte/half store | RMW_RD in cycle 1, RMW_WR in cycle 2 | cycle 3 | cycle 4 |
| Error | none | cycle 1 | cycle 2 |

- Masters must keep `req` and all attributes stable until they sample ack. They may drop `req`, or present a new request, in the cycle after ack.
- Changing the attributes after grant has no effect on the transaction, because they are latched.
- Both masters requesting continuously are served alternately, with no starvation.
- Reset asserted mid-RMW: `dm_wr` drops immediately, no partial write occurs, and no ack is issued. After reset, m0 has priority.

## Structure

- A shared definitions header holds:
  - the state encodings;
  - the size codes `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the `ADDR_MAX` limit expression.
- One sub-module, `dm_store_merge`: combinational byte/half insertion of `wdata` into the merge word, selected by size.

## Test plan

- m0 word store `0xDEADBEEF` @ 0x010, then a word load @ 0x010:
  - m0 ack at cycle 2 of each transaction;
  - load `rdata` = `0xDEADBEEF`.
- Word `0x11223344` @ 0x020, then m1 byte store `0xAA` @ 0x020:
  - `dm_rd` in cycle 1, then `dm_wr` in cycle 2 with `dm_din` = `0xAA223344`;
  - ack at cycle 3.
- Half store `0xBEEF` @ 0x020 over `0xAA223344`:
  - the next word load @ 0x020 returns `0xBEEF3344`.
- m0 and m1 request together from reset, both held continuously:
  - grant order m0, m1, m0, m1;
  - exactly one ack per transaction.
- m1 word load @ 0xFFE:
  - no `dm_cs` assertion;
  - ack with err at cycle 1, `rdata` = 0.
- Assert `reset_n` low during RMW_WR:
  - `dm_wr` falls without waiting for a clock;
  - memory is unchanged on re-read;
  - all outputs hold their reset values.
